// File: rtl/id_ex_if.sv
// ID/EX stage bundle: decode-side control/operands in, EX-side registered copies,
// hazard stall and debug counters out.
interface id_ex_if #(
   parameter int DW = 32,
   parameter int CW = 16
);
   logic          Reg_Write, memWrite, memRead, RegDst, ALUsrc, memToReg, link31, writePC;
   logic [2:0]    ALU_control;
   logic [DW-1:0] id_rd1, id_rd2, id_imm, id_pc4;
   logic [4:0]    id_rs, id_rt, id_rd;
   logic          id_use_rs, id_use_rt;
   logic          flush, hold;

   logic          ex_Reg_Write, ex_memWrite, ex_memRead, ex_RegDst, ex_ALUsrc, ex_memToReg;
   logic          ex_link31, ex_writePC;
   logic [2:0]    ex_ALU_control;
   logic [DW-1:0] ex_rd1, ex_rd2, ex_imm, ex_pc4;
   logic [4:0]    ex_rs, ex_rt, ex_rd;
   logic          ex_valid;
   logic          stall;
   logic [CW-1:0] stall_count, flush_count;

   modport master (
      output Reg_Write, memWrite, memRead, RegDst, ALUsrc, memToReg, link31, writePC,
             ALU_control, id_rd1, id_rd2, id_imm, id_pc4, id_rs, id_rt, id_rd,
             id_use_rs, id_use_rt, flush, hold,
      input  ex_Reg_Write, ex_memWrite, ex_memRead, ex_RegDst, ex_ALUsrc, ex_memToReg,
             ex_link31, ex_writePC, ex_ALU_control, ex_rd1, ex_rd2, ex_imm, ex_pc4,
             ex_rs, ex_rt, ex_rd, ex_valid, stall, stall_count, flush_count
   );

   modport slave (
      input  Reg_Write, memWrite, memRead, RegDst, ALUsrc, memToReg, link31, writePC,
             ALU_control, id_rd1, id_rd2, id_imm, id_pc4, id_rs, id_rt, id_rd,
             id_use_rs, id_use_rt, flush, hold,
      output ex_Reg_Write, ex_memWrite, ex_memRead, ex_RegDst, ex_ALUsrc, ex_memToReg,
             ex_link31, ex_writePC, ex_ALU_control, ex_rd1, ex_rd2, ex_imm, ex_pc4,
             ex_rs, ex_rt, ex_rd, ex_valid, stall, stall_count, flush_count
   );
endinterface

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion on
// stall/flush, whole-stage hold, and saturating stall/flush event counters.
module id_ex_pipe #(
   parameter int DW = 32,
   parameter int CW = 16
) (
   input logic   clk,
   input logic   rst,
   id_ex_if.slave bus
);

   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

   typedef struct packed {
      logic          Reg_Write;
      logic          memWrite;
      logic          memRead;
      logic          RegDst;
      logic          ALUsrc;
      logic          memToReg;
      logic          link31;
      logic          writePC;
      logic [2:0]    ALU_control;
      logic [DW-1:0] rd1;
      logic [DW-1:0] rd2;
      logic [DW-1:0] imm;
      logic [DW-1:0] pc4;
      logic [4:0]    rs;
      logic [4:0]    rt;
      logic [4:0]    rd;
      logic          valid;
   } ex_t;

   ex_t           ex_q;
   ex_t           id_word;
   logic [CW-1:0] stall_cnt;
   logic [CW-1:0] flush_cnt;
   logic          lu;

   always_comb begin
      id_word             = '0;
      id_word.Reg_Write   = bus.Reg_Write;
      id_word.memWrite    = bus.memWrite;
      id_word.memRead     = bus.memRead;
      id_word.RegDst      = bus.RegDst;
      id_word.ALUsrc      = bus.ALUsrc;
      id_word.memToReg    = bus.memToReg;
      id_word.link31      = bus.link31;
      id_word.writePC     = bus.writePC;
      id_word.ALU_control = bus.ALU_control;
      id_word.rd1         = bus.id_rd1;
      id_word.rd2         = bus.id_rd2;
      id_word.imm         = bus.id_imm;
      id_word.pc4         = bus.id_pc4;
      id_word.rs          = bus.id_rs;
      id_word.rt          = bus.id_rt;
      id_word.rd          = bus.id_rd;
      id_word.valid       = 1'b1;
   end

   // Only registered EX fields feed the hazard term, so stall never loops through ex_*.
   always_comb begin
      lu = ex_q.memRead && (ex_q.rt != 5'd0) &&
           ((bus.id_use_rs && (ex_q.rt == bus.id_rs)) ||
            (bus.id_use_rt && (ex_q.rt == bus.id_rt)));
   end

   assign bus.stall = lu && !bus.flush && !bus.hold;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_q      <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (!bus.hold) begin
         if (bus.flush) begin
            ex_q <= '0;
            if (flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + CW'(1);
         end else if (lu) begin
            ex_q <= '0;
            if (stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CW'(1);
         end else begin
            ex_q <= id_word;
         end
      end
   end

   assign bus.ex_Reg_Write   = ex_q.Reg_Write;
   assign bus.ex_memWrite    = ex_q.memWrite;
   assign bus.ex_memRead     = ex_q.memRead;
   assign bus.ex_RegDst      = ex_q.RegDst;
   assign bus.ex_ALUsrc      = ex_q.ALUsrc;
   assign bus.ex_memToReg    = ex_q.memToReg;
   assign bus.ex_link31      = ex_q.link31;
   assign bus.ex_writePC     = ex_q.writePC;
   assign bus.ex_ALU_control = ex_q.ALU_control;
   assign bus.ex_rd1         = ex_q.rd1;
   assign bus.ex_rd2         = ex_q.rd2;
   assign bus.ex_imm         = ex_q.imm;
   assign bus.ex_pc4         = ex_q.pc4;
   assign bus.ex_rs          = ex_q.rs;
   assign bus.ex_rt          = ex_q.rt;
   assign bus.ex_rd          = ex_q.rd;
   assign bus.ex_valid       = ex_q.valid;
   assign bus.stall_count    = stall_cnt;
   assign bus.flush_count    = flush_cnt;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Scoreboard bench for id_ex_pipe: directed hazard/hold/flush scenarios, random
// traffic against an instruction-level reference model, counter saturation, async reset.
module tb_id_ex_pipe;
   localparam int DW   = 32;
   localparam int CW   = 16;
   localparam int CMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   id_ex_if #(.DW(DW), .CW(CW)) bus ();
   id_ex_pipe #(.DW(DW), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct packed {
      logic rw, mw, mr, rdst, asrc, m2r, l31, wpc;
      logic [2:0] alu;
      logic [DW-1:0] rd1, rd2, imm, pc4;
      logic [4:0] rs, rt, rd;
   } instr_t;

   typedef struct packed {
      instr_t ins;
      logic valid;
      logic [CW-1:0] scnt, fcnt;
   } ex_t;

   typedef struct packed {
      instr_t ins;
      logic use_rs, use_rt, flush, hold;
   } stim_t;

   ex_t  model = '0;
   ex_t  exp_q[$];
   logic stall_q[$];
   int   compared = 0;
   int   mismatched = 0;

   // A load in EX whose destination register the ID instruction actually reads.
   function automatic bit reads_loaded_reg(ex_t m, stim_t s);
      if (!m.ins.mr || m.ins.rt == 5'd0) return 1'b0;
      return (s.use_rs && s.ins.rs == m.ins.rt) || (s.use_rt && s.ins.rt == m.ins.rt);
   endfunction

   function automatic logic [CW-1:0] bump(logic [CW-1:0] c);
      int v;
      v = int'(c) + 1;
      if (v > CMAX) v = CMAX;
      return CW'(v);
   endfunction

   function automatic ex_t model_next(ex_t m, stim_t s);
      ex_t n;
      n = m;
      if (s.hold) return m;
      if (s.flush) begin
         n.ins = '0; n.valid = 1'b0; n.fcnt = bump(m.fcnt);
      end else if (reads_loaded_reg(m, s)) begin
         n.ins = '0; n.valid = 1'b0; n.scnt = bump(m.scnt);
      end else begin
         n.ins = s.ins; n.valid = 1'b1;
      end
      return n;
   endfunction

   function automatic ex_t sample();
      ex_t e;
      e.ins.rw  = bus.ex_Reg_Write;  e.ins.mw   = bus.ex_memWrite;
      e.ins.mr  = bus.ex_memRead;    e.ins.rdst = bus.ex_RegDst;
      e.ins.asrc = bus.ex_ALUsrc;    e.ins.m2r  = bus.ex_memToReg;
      e.ins.l31 = bus.ex_link31;     e.ins.wpc  = bus.ex_writePC;
      e.ins.alu = bus.ex_ALU_control;
      e.ins.rd1 = bus.ex_rd1; e.ins.rd2 = bus.ex_rd2;
      e.ins.imm = bus.ex_imm; e.ins.pc4 = bus.ex_pc4;
      e.ins.rs  = bus.ex_rs;  e.ins.rt  = bus.ex_rt; e.ins.rd = bus.ex_rd;
      e.valid = bus.ex_valid;
      e.scnt  = bus.stall_count;
      e.fcnt  = bus.flush_count;
      return e;
   endfunction

   task automatic drive(stim_t s);
      bus.Reg_Write = s.ins.rw;  bus.memWrite = s.ins.mw;  bus.memRead  = s.ins.mr;
      bus.RegDst    = s.ins.rdst; bus.ALUsrc  = s.ins.asrc; bus.memToReg = s.ins.m2r;
      bus.link31    = s.ins.l31; bus.writePC  = s.ins.wpc; bus.ALU_control = s.ins.alu;
      bus.id_rd1 = s.ins.rd1; bus.id_rd2 = s.ins.rd2;
      bus.id_imm = s.ins.imm; bus.id_pc4 = s.ins.pc4;
      bus.id_rs  = s.ins.rs;  bus.id_rt  = s.ins.rt; bus.id_rd = s.ins.rd;
      bus.id_use_rs = s.use_rs; bus.id_use_rt = s.use_rt;
      bus.flush = s.flush; bus.hold = s.hold;
   endtask

   task automatic check(string tag, logic [255:0] got, logic [255:0] want);
      compared++;
      if (got !== want) begin
         mismatched++;
         $display("FAIL %s @%0t got=%0h want=%0h", tag, $time, got, want);
      end
   endtask

   task automatic step(stim_t s);
      @(posedge clk);
      #2;
      drive(s);
      rst = 1'b1;
      #1;
      stall_q.push_back(reads_loaded_reg(model, s) && !s.flush && !s.hold);
      model = model_next(model, s);
      exp_q.push_back(model);
   endtask

   function automatic stim_t rand_stim();
      stim_t s;
      s.ins.rw = 1'($urandom); s.ins.mw = 1'($urandom);
      s.ins.mr = ($urandom_range(0, 9) < 4);
      s.ins.rdst = 1'($urandom); s.ins.asrc = 1'($urandom); s.ins.m2r = 1'($urandom);
      s.ins.l31 = 1'($urandom); s.ins.wpc = 1'($urandom);
      s.ins.alu = 3'($urandom);
      s.ins.rd1 = $urandom; s.ins.rd2 = $urandom; s.ins.imm = $urandom; s.ins.pc4 = $urandom;
      s.ins.rs = 5'($urandom_range(0, 3));
      s.ins.rt = 5'($urandom_range(0, 3));
      s.ins.rd = 5'($urandom);
      s.use_rs = 1'($urandom); s.use_rt = 1'($urandom);
      s.flush = ($urandom_range(0, 9) == 0);
      s.hold  = ($urandom_range(0, 9) == 0);
      return s;
   endfunction

   always @(posedge clk) begin : mon_ex
      ex_t e, g;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = sample();
         check("ex_fields", 256'(g.ins), 256'(e.ins));
         check("ex_valid", 256'(g.valid), 256'(e.valid));
         check("stall_count", 256'(g.scnt), 256'(e.scnt));
         check("flush_count", 256'(g.fcnt), 256'(e.fcnt));
      end
   end

   always @(negedge clk) begin : mon_stall
      logic e;
      if (stall_q.size() > 0) begin
         e = stall_q.pop_front();
         check("stall", 256'(bus.stall), 256'(e));
      end
   end

   initial begin
      stim_t s, lw, use_i;
      drive('1);
      #6;
      check("reset_outputs", 256'(sample()), 256'(0));
      check("reset_stall", 256'(bus.stall), 256'(0));

      // Release reset with a plain ALU op; first edge captures it.
      s = '0; s.ins.alu = 3'b010; s.ins.rd1 = 32'h5; s.ins.rw = 1'b1; s.ins.rd = 5'd3;
      step(s);

      // Load-use: lw r8 then add reading r8.
      lw = '0; lw.ins.mr = 1'b1; lw.ins.rw = 1'b1; lw.ins.m2r = 1'b1; lw.ins.rt = 5'd8;
      use_i = '0; use_i.ins.rw = 1'b1; use_i.ins.rs = 5'd8; use_i.ins.rd = 5'd9; use_i.use_rs = 1'b1;
      step(lw);
      step(use_i);
      check("lu_stall_hi", 256'(bus.stall), 256'(1));
      step(use_i);
      check("lu_stall_lo", 256'(bus.stall), 256'(0));
      check("lu_stall_count", 256'(bus.stall_count), 256'(1));
      check("lu_bubble_valid", 256'(bus.ex_valid), 256'(0));

      // No false stall: r0 destination, or source not used.
      s = lw; s.ins.rt = 5'd0;
      step(s);
      s = use_i; s.ins.rs = 5'd0; s.ins.rt = 5'd0; s.use_rt = 1'b1;
      step(s);
      check("r0_no_stall", 256'(bus.stall), 256'(0));
      step(lw);
      s = use_i; s.use_rs = 1'b0; s.use_rt = 1'b0;
      step(s);
      check("unused_no_stall", 256'(bus.stall), 256'(0));

      // Flush beats hazard.
      step(lw);
      s = use_i; s.flush = 1'b1;
      step(s);
      check("flush_over_lu", 256'(bus.stall), 256'(0));

      // Hold with a hazard presented; stall must reappear after release.
      step(lw);
      for (int i = 0; i < 3; i++) begin
         s = rand_stim(); s.hold = 1'b1; s.flush = 1'b0;
         if (i == 1) begin s = use_i; s.hold = 1'b1; end
         step(s);
         check("hold_no_stall", 256'(bus.stall), 256'(0));
      end
      step(use_i);
      check("post_hold_stall", 256'(bus.stall), 256'(1));

      for (int i = 0; i < 1500; i++) step(rand_stim());

      // Saturate the flush counter.
      for (int i = 0; i < (1 << CW) + 2; i++) begin
         s = rand_stim(); s.flush = 1'b1; s.hold = 1'b0;
         step(s);
      end
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      @(negedge clk);
      check("scoreboard_drained", 256'(exp_q.size()), 256'(0));
      check("flush_saturated", 256'(bus.flush_count), 256'(16'hFFFF));

      // Async reset between edges.
      #2;
      rst = 1'b0;
      #1;
      check("async_reset", 256'(sample()), 256'(0));
      check("async_reset_stall", 256'(bus.stall), 256'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
